burst_write_master: RTL and testbench

Bursting Avalon-MM write master that consumes a word stream from user logic, typically the output FIFO of the bursting read master in a memory-to-memory copy path, and posts it to memory as aligned bursts. Control logic supplies a word-aligned base address, a length in bytes and a `go` pulse. User logic pushes words into an internal show-ahead FIFO. The block asserts `control_done` once the last beat of the last burst has been accepted.

---
 rtl/burst_master_pkg.sv | 25 ++
 rtl/burst_write_master_fifo.sv | 52 +++++
 rtl/burst_write_master.sv | 124 ++++++++++++
 tb/tb_burst_write_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_master_pkg.sv
// Shared definitions for the bursting read/write masters: FSM state encoding
// and the burst-size helper that realigns transfers to burst boundaries.
package burst_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_DATA = 2'd1,
      ST_BURST     = 2'd2
   } burst_state_e;

   // Beats in the next burst: fill up to the next burst boundary, but never
   // beyond the words still owed to the transfer.
   function automatic logic [31:0] calc_burst_count(
      input logic [31:0] word_addr,
      input logic [31:0] words_left,
      input int unsigned max_burst
   );
      logic [31:0] offset;
      logic [31:0] room;
      offset = word_addr & (max_burst - 1);
      room   = max_burst - offset;
      return (room < words_left) ? room : words_left;
   endfunction

endpackage

// File: rtl/burst_write_master_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; pushes while full are
// dropped even when a pop happens in the same cycle.
module burst_write_fifo #(
   parameter int DATAWIDTH  = 32,
   parameter int DEPTH      = 32,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push_i,
   input  logic [DATAWIDTH-1:0]  data_i,
   input  logic                  pop_i,
   output logic [DATAWIDTH-1:0]  head_o,
   output logic [DEPTH_LOG2:0]   used_o,
   output logic                  full_o
);

   logic [DATAWIDTH-1:0]  mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   used_q;
   logic                  push_ok;
   logic                  pop_ok;

   assign full_o  = (used_q == (DEPTH_LOG2+1)'(DEPTH));
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && (used_q != '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign used_o  = used_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   used_q <= used_q + 1'b1;
            2'b01:   used_q <= used_q - 1'b1;
            default: used_q <= used_q;
         endcase
      end
   end

   // Storage is not reset; the pointers alone define the contents.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/burst_write_master.sv
// Bursting Avalon-MM write master: drains the internal FIFO into memory as
// boundary-aligned bursts, starting a burst only once all its data is buffered.
module burst_write_master
   import burst_master_pkg::*;
#(
   parameter int DATAWIDTH       = 32,
   parameter int MAXBURSTCOUNT   = 4,
   parameter int BURSTCOUNTWIDTH = 3,
   parameter int BYTEENABLEWIDTH = 4,
   parameter int ADDRESSWIDTH    = 32,
   parameter int FIFODEPTH       = 32,
   parameter int FIFODEPTH_LOG2  = 5
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       control_fixed_location,
   input  logic [ADDRESSWIDTH-1:0]    control_write_base,
   input  logic [ADDRESSWIDTH-1:0]    control_write_length,
   input  logic                       control_go,
   output logic                       control_done,
   input  logic                       user_write_buffer,
   input  logic [DATAWIDTH-1:0]       user_buffer_data,
   output logic                       user_buffer_full,
   output logic [ADDRESSWIDTH-1:0]    master_address,
   output logic                       master_write,
   output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
   output logic [DATAWIDTH-1:0]       master_writedata,
   output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
   input  logic                       master_waitrequest
);

   localparam int BYTE_SHIFT = $clog2(BYTEENABLEWIDTH);

   burst_state_e                state_q;
   logic [ADDRESSWIDTH-1:0]     addr_q;
   logic [ADDRESSWIDTH-1:0]     len_q;
   logic                        fixed_q;
   logic [ADDRESSWIDTH-1:0]     master_address_q;
   logic [BURSTCOUNTWIDTH-1:0]  burstcount_q;
   logic [BURSTCOUNTWIDTH-1:0]  beats_left_q;
   logic                        write_q;

   logic [31:0]                 count_d;
   logic [ADDRESSWIDTH-1:0]     len_d;
   logic [ADDRESSWIDTH-1:0]     addr_d;
   logic [ADDRESSWIDTH-1:0]     go_len_d;
   logic [FIFODEPTH_LOG2:0]     fifo_used;
   logic                        fifo_pop;

   burst_write_fifo #(
      .DATAWIDTH  (DATAWIDTH),
      .DEPTH      (FIFODEPTH),
      .DEPTH_LOG2 (FIFODEPTH_LOG2)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (user_write_buffer),
      .data_i  (user_buffer_data),
      .pop_i   (fifo_pop),
      .head_o  (master_writedata),
      .used_o  (fifo_used),
      .full_o  (user_buffer_full)
   );

   assign count_d  = calc_burst_count(32'(addr_q >> BYTE_SHIFT), 32'(len_q >> BYTE_SHIFT),
                                      MAXBURSTCOUNT);
   assign len_d    = len_q - (ADDRESSWIDTH'(burstcount_q) << BYTE_SHIFT);
   assign addr_d   = fixed_q ? addr_q : addr_q + (ADDRESSWIDTH'(burstcount_q) << BYTE_SHIFT);
   // Sub-word length bits are discarded so a partial word never starts a transfer.
   assign go_len_d = control_write_length & ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
   assign fifo_pop = (state_q == ST_BURST) && !master_waitrequest;

   assign control_done      = (state_q == ST_IDLE);
   assign master_write      = write_q;
   assign master_address    = master_address_q;
   assign master_burstcount = burstcount_q;
   assign master_byteenable = '1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         addr_q           <= '0;
         len_q            <= '0;
         fixed_q          <= 1'b0;
         master_address_q <= '0;
         burstcount_q     <= '0;
         beats_left_q     <= '0;
         write_q          <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (control_go) begin
                  addr_q  <= control_write_base;
                  len_q   <= go_len_d;
                  fixed_q <= control_fixed_location;
                  if (go_len_d != '0) state_q <= ST_WAIT_DATA;
               end
            end
            ST_WAIT_DATA: begin
               if (32'(fifo_used) >= count_d) begin
                  master_address_q <= addr_q;
                  burstcount_q     <= BURSTCOUNTWIDTH'(count_d);
                  beats_left_q     <= BURSTCOUNTWIDTH'(count_d);
                  write_q          <= 1'b1;
                  state_q          <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (!master_waitrequest) begin
                  beats_left_q <= beats_left_q - 1'b1;
                  if (beats_left_q == BURSTCOUNTWIDTH'(1)) begin
                     write_q <= 1'b0;
                     len_q   <= len_d;
                     addr_q  <= addr_d;
                     state_q <= (len_d == '0) ? ST_IDLE : ST_WAIT_DATA;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_write_master.sv
// Bench for burst_write_master: directed transfers with hand-listed burst
// tables, a model FIFO for write data, and a negedge monitor that drives stalls.
module tb_burst_write_master;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int BCW = 3;
   localparam int BEW = 4;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           control_fixed_location = 1'b0;
   logic [AW-1:0]  control_write_base = '0;
   logic [AW-1:0]  control_write_length = '0;
   logic           control_go = 1'b0;
   logic           control_done;
   logic           user_write_buffer = 1'b0;
   logic [DW-1:0]  user_buffer_data = '0;
   logic           user_buffer_full;
   logic [AW-1:0]  master_address;
   logic           master_write;
   logic [BEW-1:0] master_byteenable;
   logic [DW-1:0]  master_writedata;
   logic [BCW-1:0] master_burstcount;
   logic           master_waitrequest = 1'b0;

   always #5 clk = ~clk;

   burst_write_master #(
      .DATAWIDTH(DW), .MAXBURSTCOUNT(4), .BURSTCOUNTWIDTH(BCW), .BYTEENABLEWIDTH(BEW),
      .ADDRESSWIDTH(AW), .FIFODEPTH(32), .FIFODEPTH_LOG2(5)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .control_fixed_location(control_fixed_location),
      .control_write_base(control_write_base),
      .control_write_length(control_write_length),
      .control_go(control_go), .control_done(control_done),
      .user_write_buffer(user_write_buffer), .user_buffer_data(user_buffer_data),
      .user_buffer_full(user_buffer_full),
      .master_address(master_address), .master_write(master_write),
      .master_byteenable(master_byteenable), .master_writedata(master_writedata),
      .master_burstcount(master_burstcount), .master_waitrequest(master_waitrequest)
   );

   // Expected beats as {address, burstcount}; data comes from the model FIFO.
   logic [AW+BCW-1:0] exp_q[$];
   logic [DW-1:0]     data_model_q[$];
   int                vectors = 0;
   int                miscompares = 0;
   bit                sb_en = 1'b1;
   bit                stall_mode = 1'b0;
   bit                burst_open = 1'b0;
   bit                done_pending = 1'b0;
   int                beat_idx = 0;
   int                stall_cnt = 0;
   int                beats_seen = 0;
   logic [AW-1:0]     burst_addr;
   logic [BCW-1:0]    burst_bc;
   logic [DW-1:0]     next_word = 32'hA000_0000;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: checks every presented beat, then decides waitrequest for the next edge.
   initial begin
      logic [AW+BCW-1:0] e;
      forever begin
         @(negedge clk);
         if (done_pending) begin
            check("done_after_last_beat", 64'(control_done), 64'd1);
            done_pending = 1'b0;
         end
         if (sb_en && master_write) begin
            if (!burst_open) begin
               burst_open = 1'b1;
               burst_addr = master_address;
               burst_bc   = master_burstcount;
               check("data_buffered_at_start", 64'(data_model_q.size() >= int'(master_burstcount)), 64'd1);
            end
            if (master_waitrequest) begin
               check("stall_addr_stable", 64'(master_address), 64'(burst_addr));
               check("stall_bc_stable", 64'(master_burstcount), 64'(burst_bc));
               stall_cnt++;
            end else begin
               if (exp_q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL unexpected_beat: addr 0x%0h bc %0d, none required", master_address, master_burstcount);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_addr", 64'(master_address), 64'(e[AW+BCW-1:BCW]));
                  check("beat_bc", 64'(master_burstcount), 64'(e[BCW-1:0]));
               end
               if (data_model_q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL beat_without_data: data 0x%0h, no word pushed", master_writedata);
               end else begin
                  check("beat_data", 64'(master_writedata), 64'(data_model_q.pop_front()));
               end
               beats_seen++;
               beat_idx++;
               if (beat_idx >= int'(burst_bc)) begin
                  beat_idx = 0; stall_cnt = 0; burst_open = 1'b0;
                  if (exp_q.size() == 0) begin
                     check("done_low_on_last_beat", 64'(control_done), 64'd0);
                     done_pending = 1'b1;
                  end
               end
            end
         end
         master_waitrequest = stall_mode && (beat_idx == 1) && (stall_cnt < 3);
      end
   end

   task automatic push_word();
      user_write_buffer = 1'b1;
      user_buffer_data  = next_word;
      @(posedge clk); #1;
      user_write_buffer = 1'b0;
      if (data_model_q.size() < 32) data_model_q.push_back(next_word);
      next_word = next_word + 1;
   endtask

   task automatic push_n(input int n);
      for (int i = 0; i < n; i++) push_word();
   endtask

   task automatic go(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic fixed);
      control_write_base = base;
      control_write_length = len;
      control_fixed_location = fixed;
      control_go = 1'b1;
      @(posedge clk); #1;
      control_go = 1'b0;
   endtask

   task automatic expect_burst(input logic [AW-1:0] addr, input logic [BCW-1:0] bc);
      for (int i = 0; i < int'(bc); i++) exp_q.push_back({addr, bc});
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      repeat (2) begin @(posedge clk); #1; end
      while (!control_done && n < 2000) begin @(posedge clk); #1; n++; end
      check({name, "_done"}, 64'(control_done), 64'd1);
      check({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1);
   end

   initial begin
      int start;
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", 64'(control_done), 64'd1);
      check("rst_write", 64'(master_write), 64'd0);
      check("rst_address", 64'(master_address), 64'd0);
      check("rst_burstcount", 64'(master_burstcount), 64'd0);
      check("rst_full", 64'(user_buffer_full), 64'd0);
      check("byteenable", 64'(master_byteenable), 64'hF);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Zero (and sub-word) length: no transfer.
      go(32'h0, 32'd0, 1'b0);
      go(32'h0, 32'd3, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      check("zero_len_done", 64'(control_done), 64'd1);
      check("zero_len_write", 64'(master_write), 64'd0);

      // T1: aligned, preloaded, go-to-write latency.
      push_n(16);
      expect_burst(32'h100, 3'd4); expect_burst(32'h110, 3'd4);
      expect_burst(32'h120, 3'd4); expect_burst(32'h130, 3'd4);
      go(32'h100, 32'd64, 1'b0);
      check("t1_cycle1_write", 64'(master_write), 64'd0);
      check("t1_cycle1_done", 64'(control_done), 64'd0);
      @(posedge clk); #1;
      check("t1_cycle2_write", 64'(master_write), 64'd1);
      wait_done("t1");

      // T2: unaligned base realigns; a second go mid-transfer is ignored.
      push_n(6);
      expect_burst(32'h104, 3'd3); expect_burst(32'h110, 3'd3);
      go(32'h104, 32'd24, 1'b0);
      go(32'h800, 32'd16, 1'b0);
      wait_done("t2");

      // T3: 3-cycle stall on beat 2 of every burst.
      stall_mode = 1'b1;
      push_n(8);
      expect_burst(32'h308, 3'd2); expect_burst(32'h310, 3'd4); expect_burst(32'h320, 3'd2);
      go(32'h308, 32'd32, 1'b0);
      wait_done("t3");
      stall_mode = 1'b0;

      // T4: data trickled one word every five cycles.
      expect_burst(32'h400, 3'd4); expect_burst(32'h410, 3'd4);
      go(32'h400, 32'd32, 1'b0);
      for (int i = 0; i < 8; i++) begin
         push_word();
         repeat (4) begin @(posedge clk); #1; end
      end
      wait_done("t4");

      // T5: fixed location.
      push_n(8);
      expect_burst(32'h200, 3'd4); expect_burst(32'h200, 3'd4);
      go(32'h200, 32'd32, 1'b1);
      wait_done("t5");

      // T6: fill to full, drop the 33rd word, drain it all.
      push_n(31);
      check("t6_not_full_31", 64'(user_buffer_full), 64'd0);
      push_word();
      check("t6_full_32", 64'(user_buffer_full), 64'd1);
      push_word();
      check("t6_full_after_drop", 64'(user_buffer_full), 64'd1);
      for (int i = 0; i < 8; i++) expect_burst(32'(i * 16), 3'd4);
      go(32'h0, 32'd128, 1'b0);
      wait_done("t6");
      check("t6_drained_not_full", 64'(user_buffer_full), 64'd0);

      // Reset mid-burst; the first beat here also shows the dropped word is gone.
      push_n(8);
      expect_burst(32'h500, 3'd4); expect_burst(32'h510, 3'd4);
      go(32'h500, 32'd32, 1'b0);
      start = beats_seen;
      n = 0;
      while (beats_seen == start && n < 100) begin @(posedge clk); #1; n++; end
      check("mid_burst_first_beat_seen", 64'(beats_seen > start), 64'd1);
      check("mid_burst_write", 64'(master_write), 64'd1);
      sb_en = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_write", 64'(master_write), 64'd0);
      check("mid_rst_done", 64'(control_done), 64'd1);
      check("mid_rst_address", 64'(master_address), 64'd0);
      check("mid_rst_burstcount", 64'(master_burstcount), 64'd0);
      reset_n = 1'b1;
      exp_q.delete();
      data_model_q.delete();
      beat_idx = 0; stall_cnt = 0; burst_open = 1'b0; done_pending = 1'b0;
      @(posedge clk); #1;

      // After reset the FIFO is empty, so a new transfer must wait for data.
      go(32'h600, 32'd16, 1'b0);
      repeat (10) begin @(posedge clk); #1; end
      check("post_rst_no_write", 64'(master_write), 64'd0);
      check("post_rst_waiting", 64'(control_done), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
